// File: rtl/pc_branch_sequencer_pkg.sv
// Shared definitions for the PC branch sequencer: branch type encodings,
// sequencer state enum and the sequential PC increment.
package pc_branch_sequencer_pkg;

  typedef enum logic [1:0] {
    BR_BEQZ = 2'b00,  // taken when operand == 0
    BR_BNEZ = 2'b01,  // taken when operand != 0
    BR_JMP  = 2'b10,  // always taken
    BR_RSVD = 2'b11   // never taken, behaves as a no-op
  } br_type_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Width of the bubble-window counter; covers FLUSH_CYCLES up to 15.
  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/pc_branch_sequencer_if.sv
// Branch-resolution / fetch-side bundle of the PC branch sequencer.
//   master : execute/fetch environment; drives stall and the resolved branch,
//            observes pc, pc_valid, flush, taken, align_err, taken_cnt.
//   slave  : the sequencer itself.
interface pc_branch_sequencer_if;
  import pc_branch_sequencer_pkg::*;

  logic        stall;
  logic        br_valid;
  br_type_e    br_type;
  logic        br_z;
  logic [31:0] br_target;

  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        taken;
  logic        align_err;
  logic [15:0] taken_cnt;

  modport master (
    output stall, br_valid, br_type, br_z, br_target,
    input  pc, pc_valid, flush, taken, align_err, taken_cnt
  );

  modport slave (
    input  stall, br_valid, br_type, br_z, br_target,
    output pc, pc_valid, flush, taken, align_err, taken_cnt
  );

endinterface

// File: rtl/pc_branch_sequencer_branch_decide.sv
// Combinational branch condition evaluation.
//   br_valid : branch resolved this cycle
//   br_type  : BEQZ / BNEZ / JMP / reserved
//   br_z     : operand-is-zero flag
//   hit      : branch condition satisfied (state gating is done by the caller)
module pc_branch_sequencer_branch_decide
  import pc_branch_sequencer_pkg::*;
(
  input  logic     br_valid,
  input  br_type_e br_type,
  input  logic     br_z,
  output logic     hit
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    unique case (br_type)
      BR_BEQZ: cond = br_z;
      BR_BNEZ: cond = ~br_z;
      BR_JMP:  cond = 1'b1;
      BR_RSVD: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  assign hit = br_valid & cond;

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program-counter sequencer: redirects the fetch PC on taken branches and
// holds flush high for a fixed bubble window to kill wrong-path instructions.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of pc_branch_sequencer_if
//              in : stall, br_valid, br_type, br_z, br_target
//              out: pc, pc_valid, flush, taken, align_err, taken_cnt (all registered)
module pc_branch_sequencer
  import pc_branch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  pc_branch_sequencer_if.slave bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  seq_state_e             state_q;
  logic [31:0]            pc_q;
  logic                   pc_valid_q;
  logic                   flush_q;
  logic                   taken_q;
  logic                   align_err_q;
  logic [15:0]            taken_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;

  logic hit;
  logic take;

  pc_branch_sequencer_branch_decide u_branch_decide (
    .br_valid (bus.br_valid),
    .br_type  (bus.br_type),
    .br_z     (bus.br_z),
    .hit      (hit)
  );

  // Branches seen during the bubble window are on the wrong path.
  assign take = hit & (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      flush_q     <= 1'b0;
      taken_q     <= 1'b0;
      align_err_q <= 1'b0;
      taken_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_valid_q  <= 1'b1;
      taken_q     <= 1'b0;
      align_err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (take) begin
            // Redirect wins over stall; low bits are dropped, not trapped.
            pc_q        <= {bus.br_target[31:2], 2'b00};
            taken_q     <= 1'b1;
            align_err_q <= |bus.br_target[1:0];
            flush_cnt_q <= FLUSH_LOAD;
            flush_q     <= 1'b1;
            state_q     <= ST_FLUSH;
            if (taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
          end else if (!bus.stall && pc_valid_q) begin
            // Hold on the first post-reset cycle so RESET_PC is actually requested.
            pc_q <= pc_q + PC_STEP;
          end
        end
        ST_FLUSH: begin
          if (!bus.stall) pc_q <= pc_q + PC_STEP;
          // Counter runs regardless of stall so the window length is fixed.
          if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
            state_q     <= ST_RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.flush     = flush_q;
  assign bus.taken     = taken_q;
  assign bus.align_err = align_err_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;
  import pc_branch_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          FLUSH_N = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_branch_sequencer_if bus_if ();

  pc_branch_sequencer #(
    .RESET_PC     (RST_PC),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        taken;
    logic        align_err;
    logic [15:0] taken_cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_flush_left;
  logic        m_taken;
  logic        m_align;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge for the given inputs.
  task automatic model_step(input logic r, input logic s, input logic bv, input br_type_e t,
                            input logic z, input logic [31:0] tgt);
    logic cond;
    logic was_valid;
    if (r) begin
      m_pc = RST_PC; m_valid = 0; m_flush_left = 0; m_taken = 0; m_align = 0; m_cnt = 0;
      return;
    end
    case (t)
      BR_BEQZ: cond = z;
      BR_BNEZ: cond = !z;
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    was_valid = m_valid;
    m_valid   = 1'b1;
    m_taken   = 1'b0;
    m_align   = 1'b0;
    if (m_flush_left == 0 && bv && cond) begin
      m_pc         = tgt & 32'hFFFF_FFFC;
      m_taken      = 1'b1;
      m_align      = (tgt[1:0] != 2'b00);
      m_flush_left = FLUSH_N;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      if (!s && was_valid) m_pc = m_pc + 32'd4;
      if (m_flush_left > 0) m_flush_left--;
    end
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, then compare.
  task automatic cycle(input logic r, input logic s, input logic bv, input br_type_e t,
                       input logic z, input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    rst              = r;
    bus_if.stall     = s;
    bus_if.br_valid  = bv;
    bus_if.br_type   = t;
    bus_if.br_z      = z;
    bus_if.br_target = tgt;
    model_step(r, s, bv, t, z, tgt);
    e = '{pc: m_pc, pc_valid: m_valid, flush: (m_flush_left > 0), taken: m_taken,
          align_err: m_align, taken_cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    got = exp_q.pop_front();
    check_eq("pc",        bus_if.pc,               got.pc);
    check_eq("pc_valid",  {31'd0, bus_if.pc_valid},  {31'd0, got.pc_valid});
    check_eq("flush",     {31'd0, bus_if.flush},     {31'd0, got.flush});
    check_eq("taken",     {31'd0, bus_if.taken},     {31'd0, got.taken});
    check_eq("align_err", {31'd0, bus_if.align_err}, {31'd0, got.align_err});
    check_eq("taken_cnt", {16'd0, bus_if.taken_cnt}, {16'd0, got.taken_cnt});
  endtask

  task automatic idle(input logic s);
    cycle(1'b0, s, 1'b0, BR_BEQZ, 1'b0, 32'h0);
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.stall     = 1'b0;
    bus_if.br_valid  = 1'b0;
    bus_if.br_type   = BR_BEQZ;
    bus_if.br_z      = 1'b0;
    bus_if.br_target = 32'h0;

    // Reset then run
    cycle(1'b1, 1'b0, 1'b0, BR_BEQZ, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, BR_BEQZ, 1'b0, 32'h0);
    check_eq("rst_pc", bus_if.pc, 32'h100);
    check_eq("rst_valid", {31'd0, bus_if.pc_valid}, 32'd0);
    idle(1'b0);
    check_eq("run0_pc", bus_if.pc, 32'h100);
    check_eq("run0_valid", {31'd0, bus_if.pc_valid}, 32'd1);
    idle(1'b0);
    check_eq("run1_pc", bus_if.pc, 32'h104);
    idle(1'b0);
    check_eq("run2_pc", bus_if.pc, 32'h108);

    // BEQZ taken
    cycle(1'b0, 1'b0, 1'b1, BR_BEQZ, 1'b1, 32'h2000);
    check_eq("beqz_pc", bus_if.pc, 32'h2000);
    check_eq("beqz_taken", {31'd0, bus_if.taken}, 32'd1);
    check_eq("beqz_cnt", {16'd0, bus_if.taken_cnt}, 32'd1);
    idle(1'b0);
    check_eq("beqz_flush2", {31'd0, bus_if.flush}, 32'd1);
    check_eq("beqz_pulse", {31'd0, bus_if.taken}, 32'd0);
    idle(1'b0);
    check_eq("beqz_flush_end", {31'd0, bus_if.flush}, 32'd0);

    // BNEZ not taken
    cycle(1'b0, 1'b0, 1'b1, BR_BNEZ, 1'b1, 32'h9000);
    check_eq("bnez_pc", bus_if.pc, 32'h200C);
    check_eq("bnez_taken", {31'd0, bus_if.taken}, 32'd0);

    // Branch during flush is ignored
    cycle(1'b0, 1'b0, 1'b1, BR_JMP, 1'b0, 32'h3000);
    cycle(1'b0, 1'b0, 1'b1, BR_JMP, 1'b0, 32'h4000);
    check_eq("flushbr_pc", bus_if.pc, 32'h3004);
    check_eq("flushbr_cnt", {16'd0, bus_if.taken_cnt}, 32'd2);
    idle(1'b0);
    // A branch at the first RUN edge is accepted
    cycle(1'b0, 1'b0, 1'b1, BR_JMP, 1'b0, 32'h7000);
    check_eq("rerun_pc", bus_if.pc, 32'h7000);
    idle(1'b0);
    idle(1'b0);

    // Stall with misaligned redirect
    cycle(1'b0, 1'b1, 1'b1, BR_JMP, 1'b0, 32'h5002);
    check_eq("stall_pc", bus_if.pc, 32'h5000);
    check_eq("stall_align", {31'd0, bus_if.align_err}, 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_eq("stall_hold", bus_if.pc, 32'h5000);
    idle(1'b0);

    // Reserved type is a no-op
    cycle(1'b0, 1'b0, 1'b1, BR_RSVD, 1'b1, 32'h8000);
    check_eq("rsvd_pc", bus_if.pc, 32'h5008);

    // PC wrap
    cycle(1'b0, 1'b0, 1'b1, BR_JMP, 1'b0, 32'hFFFF_FFFC);
    idle(1'b0);
    check_eq("wrap_pc", bus_if.pc, 32'h0);
    idle(1'b0);

    // Reset mid-flush
    cycle(1'b0, 1'b0, 1'b1, BR_JMP, 1'b0, 32'h6000);
    cycle(1'b1, 1'b0, 1'b0, BR_BEQZ, 1'b0, 32'h0);
    check_eq("rstfl_flush", {31'd0, bus_if.flush}, 32'd0);
    check_eq("rstfl_pc", bus_if.pc, 32'h100);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), br_type_e'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
